// File: rtl/llc_arb_pkg.sv
// rtl/llc_arb_pkg.sv - shared types for the icache/dcache memory-path arbiter
package llc_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_I   = 2'd1,
      GNT_D   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

endpackage : llc_arb_pkg

// File: rtl/llc_mem_arbiter.sv
// rtl/llc_mem_arbiter.sv - round-robin icache/dcache arbiter for the cacheline adaptor path
module llc_mem_arbiter
   import llc_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp
);

   arb_state_t r_state;
   requester_t r_last_gnt;
   arb_state_t w_next_state;
   requester_t w_next_last_gnt;
   logic       w_i_req;
   logic       w_d_req;

   assign w_i_req = i_read;
   assign w_d_req = d_read | d_write;

   // Read data is broadcast to both caches; only the matching resp qualifies it.
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

   // State and fairness pointer; last_gnt resets to D so the icache wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last_gnt <= REQ_D;
      end else begin
         r_state    <= w_next_state;
         r_last_gnt <= w_next_last_gnt;
      end
   end

   // Next-state selection and request/response muxing onto the shared adaptor port.
   always_comb begin
      w_next_state    = r_state;
      w_next_last_gnt = r_last_gnt;
      m_read          = 1'b0;
      m_write         = 1'b0;
      m_wdata         = '0;
      i_resp          = 1'b0;
      d_resp          = 1'b0;
      // Address is a don't-care when no one holds the grant; pick the side that would win a tie.
      m_addr          = (r_last_gnt == REQ_D) ? i_addr : d_addr;

      unique case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               w_next_state = (r_last_gnt == REQ_D) ? GNT_I : GNT_D;
            end else if (w_i_req) begin
               w_next_state = GNT_I;
            end else if (w_d_req) begin
               w_next_state = GNT_D;
            end
         end
         GNT_I: begin
            m_read = 1'b1;
            m_addr = i_addr;
            if (m_resp) begin
               i_resp          = 1'b1;
               w_next_last_gnt = REQ_I;
               w_next_state    = RELEASE;
            end
         end
         GNT_D: begin
            // A simultaneous read and write is illegal from the dcache; the read wins.
            m_read  = d_read;
            m_write = d_write & ~d_read;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            if (m_resp) begin
               d_resp          = 1'b1;
               w_next_last_gnt = REQ_D;
               w_next_state    = RELEASE;
            end
         end
         RELEASE: begin
            // One dead cycle so the adaptor sees its request drop before any new grant.
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule : llc_mem_arbiter

// File: tb/tb_llc_mem_arbiter.sv
// tb/tb_llc_mem_arbiter.sv - randomized and directed bench for llc_mem_arbiter
module tb_llc_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_read = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata = '0;
   logic              m_resp = 1'b0;

   llc_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_resp(m_resp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: who owns the memory path (0 none, 1 icache, 2 dcache), whether a
   // post-transaction gap cycle is pending, and who was served last.
   int owner;
   bit gap;
   int last;
   bit e_i_resp, e_d_resp;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      owner = 0;
      gap   = 1'b0;
      last  = 2;
   endtask

   task automatic model_compare();
      logic              e_rd, e_wr;
      logic [ADDR_W-1:0] e_addr;
      logic [LINE_W-1:0] e_wdata;
      e_rd = 0; e_wr = 0; e_wdata = '0; e_i_resp = 0; e_d_resp = 0;
      e_addr = (last == 2) ? i_addr : d_addr;
      if (!reset && owner == 1) begin
         e_rd = 1; e_addr = i_addr; e_i_resp = m_resp;
      end else if (!reset && owner == 2) begin
         e_rd = d_read; e_wr = d_write && !d_read;
         e_addr = d_addr; e_wdata = d_wdata; e_d_resp = m_resp;
      end
      if (reset) e_addr = i_addr;
      chk("m_read", 256'(m_read), 256'(e_rd));
      chk("m_write", 256'(m_write), 256'(e_wr));
      chk("m_addr", 256'(m_addr), 256'(e_addr));
      chk("m_wdata", m_wdata, e_wdata);
      chk("i_resp", 256'(i_resp), 256'(e_i_resp));
      chk("d_resp", 256'(d_resp), 256'(e_d_resp));
      chk("i_rdata", i_rdata, m_rdata);
      chk("d_rdata", d_rdata, m_rdata);
   endtask

   task automatic model_step();
      bit ir, dr;
      if (reset) begin
         model_reset();
         return;
      end
      ir = i_read;
      dr = d_read || d_write;
      if (owner != 0) begin
         if (m_resp) begin
            last  = owner;
            owner = 0;
            gap   = 1'b1;
         end
      end else if (gap) begin
         gap = 1'b0;
      end else if (ir && dr) begin
         owner = (last == 2) ? 1 : 2;
      end else if (ir) begin
         owner = 1;
      end else if (dr) begin
         owner = 2;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_compare();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      i_read = 0; d_read = 0; d_write = 0; m_resp = 0;
      model_reset();
      settle();
      advance();
      reset = 1'b0;
   endtask

   logic [LINE_W-1:0] pat_a, pat_b;
   int g_cnt, g_tgt;

   initial begin
      model_reset();
      pat_a = rand_line();
      pat_b = rand_line();

      // Reset state
      @(posedge clk); #1;
      settle();
      chk("rst_m_read", 256'(m_read), 256'(0));
      chk("rst_m_write", 256'(m_write), 256'(0));
      chk("rst_m_wdata", m_wdata, 256'(0));
      chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
      advance();
      reset = 1'b0;

      // Icache read alone, adaptor responds on the fifth granted cycle
      i_read = 1; i_addr = 32'h0000_1000;
      settle();
      chk("ic_idle_m_read", 256'(m_read), 256'(0));
      advance();
      for (int k = 1; k <= 5; k++) begin
         m_resp  = (k == 5);
         m_rdata = (k == 5) ? pat_a : rand_line();
         settle();
         chk("ic_m_read", 256'(m_read), 256'(1));
         chk("ic_m_addr", 256'(m_addr), 256'(32'h0000_1000));
         chk("ic_d_resp", 256'(d_resp), 256'(0));
         if (k == 5) begin
            chk("ic_i_resp", 256'(i_resp), 256'(1));
            chk("ic_i_rdata", i_rdata, pat_a);
         end else begin
            chk("ic_i_resp_early", 256'(i_resp), 256'(0));
         end
         advance();
      end
      i_read = 0; m_resp = 0;
      settle();
      chk("ic_rel_m_read", 256'(m_read), 256'(0));
      chk("ic_rel_i_resp", 256'(i_resp), 256'(0));
      advance();

      // Dcache write-back alone
      d_write = 1; d_addr = 32'h8000_0040; d_wdata = pat_b;
      settle();
      advance();
      for (int k = 1; k <= 3; k++) begin
         m_resp = (k == 3);
         settle();
         chk("dw_m_write", 256'(m_write), 256'(1));
         chk("dw_m_read", 256'(m_read), 256'(0));
         chk("dw_m_wdata", m_wdata, pat_b);
         chk("dw_m_addr", 256'(m_addr), 256'(32'h8000_0040));
         chk("dw_d_resp", 256'(d_resp), 256'(k == 3));
         advance();
      end
      d_write = 0; m_resp = 0;
      settle();
      chk("dw_rel_m_write", 256'(m_write), 256'(0));
      chk("dw_rel_d_resp", 256'(d_resp), 256'(0));
      advance();

      // Contention from reset: strict alternation I, D, I, D, I, D
      do_reset();
      i_read = 1; i_addr = 32'h0000_2000;
      d_read = 1; d_addr = 32'h0000_3000;
      settle();
      for (int t = 0; t < 6; t++) begin
         advance();
         settle();
         chk("alt_m_read", 256'(m_read), 256'(1));
         chk("alt_owner_addr", 256'(m_addr), 256'((t % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000));
         advance();
         m_resp = 1;
         settle();
         chk("alt_resp", 256'({i_resp, d_resp}), 256'((t % 2 == 0) ? 2'b10 : 2'b01));
         advance();
         m_resp = 0;
         settle();
         chk("alt_rel_m_read", 256'(m_read), 256'(0));
         advance();
         settle();
      end
      advance();

      // Dcache read and write together: read wins
      i_read = 0; d_read = 0;
      do_reset();
      d_read = 1; d_write = 1; d_addr = 32'h0000_4440;
      settle();
      advance();
      settle();
      chk("rw_m_read", 256'(m_read), 256'(1));
      chk("rw_m_write", 256'(m_write), 256'(0));
      m_resp = 1;
      advance();
      m_resp = 0; d_read = 0; d_write = 0;
      settle();
      advance();

      // Reset in the third cycle of a dcache grant
      settle();
      advance();
      d_write = 1; d_addr = 32'h8000_0080; d_wdata = pat_a;
      settle();
      advance();
      for (int k = 1; k <= 2; k++) begin
         settle();
         chk("rst_mid_pre_m_write", 256'(m_write), 256'(1));
         advance();
      end
      reset = 1'b1;
      model_reset();
      m_resp = 1;
      settle();
      chk("rst_mid_m_write", 256'(m_write), 256'(0));
      chk("rst_mid_m_read", 256'(m_read), 256'(0));
      chk("rst_mid_d_resp", 256'(d_resp), 256'(0));
      advance();
      reset = 1'b0; m_resp = 0;
      i_read = 1; i_addr = 32'h0000_5000;
      settle();
      chk("rst_mid_idle", 256'(m_write | m_read), 256'(0));
      advance();
      settle();
      chk("rst_mid_tie_i", 256'(m_addr), 256'(32'h0000_5000));
      chk("rst_mid_tie_rd", 256'(m_read), 256'(1));
      m_resp = 1;
      advance();
      i_read = 0; d_write = 0; m_resp = 0;
      settle();
      advance();
      settle();
      advance();

      // Spurious adaptor response while idle
      m_resp = 1;
      settle();
      chk("spur_resp", 256'({i_resp, d_resp}), 256'(0));
      advance();
      m_resp = 0;
      settle();
      chk("spur_still_idle", 256'({m_read, m_write}), 256'(0));
      advance();

      // Randomized traffic against the model
      g_cnt = 0; g_tgt = 1;
      for (int c = 0; c < 4000; c++) begin
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            i_read = 0; d_read = 0; d_write = 0;
            model_reset();
         end
         if (!reset) begin
            if (i_read && e_i_resp) i_read = 0;
            if ((d_read || d_write) && e_d_resp) begin d_read = 0; d_write = 0; end
            if (!i_read && $urandom_range(0, 3) == 0) begin
               i_read = 1; i_addr = $urandom & 32'hFFFF_FFE0;
            end
            if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 7))
                  0:       begin d_read = 1; d_write = 1; end
                  1, 2, 3: d_read = 1;
                  default: d_write = 1;
               endcase
               d_addr  = $urandom & 32'hFFFF_FFE0;
               d_wdata = rand_line();
            end
         end
         e_i_resp = 0; e_d_resp = 0;
         if (owner != 0 && !reset) begin
            g_cnt++;
            m_resp = (g_cnt >= g_tgt);
         end else begin
            g_cnt  = 0;
            g_tgt  = $urandom_range(1, 6);
            m_resp = ($urandom_range(0, 9) == 0);
         end
         m_rdata = rand_line();
         settle();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_llc_mem_arbiter

// File: doc/llc_mem_arbiter.md
# llc_mem_arbiter

Two-way arbiter that shares the single cacheline adaptor / physical-memory path between the instruction cache (read-only) and the data cache (read/write). Sits between both cache controllers' line-miss ports and the adaptor's line-side port. Grants one requester at a time with round-robin fairness, holds the grant for one complete line transaction, then inserts one release cycle before re-arbitrating.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cacheline width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_read  in  1  icache line read request
- i_addr  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line returned to icache
- i_resp  out  1  icache transaction done, 1-cycle pulse
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line write-back request
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache write-back line
- d_rdata  out  LINE_W  line returned to dcache
- d_resp  out  1  dcache transaction done, 1-cycle pulse
- m_read  out  1  read request to adaptor
- m_write  out  1  write request to adaptor
- m_addr  out  ADDR_W  address to adaptor
- m_wdata  out  LINE_W  write line to adaptor
- m_rdata  in  LINE_W  line from adaptor
- m_resp  in  1  adaptor done pulse

## Operation
- States: IDLE, GNT_I, GNT_D, RELEASE. Register last_gnt (I or D).
- IDLE: m_read=m_write=0. Requests sampled; at the edge:
  - only icache requesting -> GNT_I; only dcache -> GNT_D.
  - both -> grant side != last_gnt.
  - none -> stay IDLE.
- GNT_I: m_read=1, m_addr=i_addr, m_wdata=0. On m_resp: i_resp=1 same cycle (combinational pass-through), last_gnt<=I, next RELEASE.
- GNT_D: m_read=d_read, m_write=d_write&~d_read (read wins if both set; illegal but defined), m_addr=d_addr, m_wdata=d_wdata. On m_resp: d_resp=1, last_gnt<=D, next RELEASE.
- RELEASE: all m_* requests 0, no resp; unconditional -> IDLE. Guarantees the adaptor sees its request low after resp, so it returns to idle and never restarts the finished transfer.
- Granted requester dropping its request before m_resp: requests still forwarded as driven; grant held until m_resp. Caches must not do this.
- i_rdata and d_rdata both driven continuously from m_rdata; only the matching resp qualifies data.
- m_resp outside GNT_I/GNT_D ignored.
- m_addr in IDLE/RELEASE: i_addr if last_gnt==D else d_addr (don't-care, defined for determinism).

## Timing
- Reset (async): state=IDLE, last_gnt=D (icache wins first tie), all resp=0, m_read=m_write=0, m_wdata=0.
- Reset mid-transaction: immediate IDLE, requests drop same cycle; no resp issued; adaptor shares reset.
- Arbitration latency: request seen in IDLE cycle N -> m_read/m_write asserted cycle N+1.
- Resp: same cycle as m_resp, no added latency.
- Turnaround: resp cycle, RELEASE cycle, IDLE cycle, then next grant; min 2 idle cycles between transactions on m_*.
- Back-to-back contention strictly alternates I, D, I, D.
- Request arriving during RELEASE is arbitrated in following IDLE.

## Structure
- Shared package llc_arb_pkg: enum arb_state_t {IDLE, GNT_I, GNT_D, RELEASE}; enum requester_t {REQ_I, REQ_D}.
- Single module, no sub-modules; one always_ff (state, last_gnt), one always_comb (next state, muxing).

## Test plan
- Icache read alone, i_addr=0x0000_1000, adaptor mock resp after 5 cycles with m_rdata=pattern A -> m_read high cycles 1..5, i_resp pulse with i_rdata=A, d_resp never high.
- Dcache write-back alone, d_addr=0x8000_0040, d_wdata=B -> m_write=1, m_wdata=B, m_addr matches; d_resp one pulse; RELEASE cycle m_write=0.
- Both request from reset -> icache first, dcache second, then icache again if both persist (alternation verified over 6 transactions).
- Dcache d_read=d_write=1 -> m_read=1, m_write=0.
- Reset asserted mid GNT_D (cycle 3 of 6) -> m_read/m_write/d_resp 0 same cycle, state IDLE, next grant goes to icache on tie.
- Spurious m_resp in IDLE -> no i_resp/d_resp, state unchanged.
